// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and the
// counter-width helper. Optional feature macro: DIV_ZERO_ERR_EN.
package restoring_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >>> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/restoring_divider_sub_nbit.sv
// N-bit combinational subtractor: diff = a - b (mod 2^N), borrow set when a < b.
// Subtract counterpart of the combinational adder; used for the trial subtraction.
module sub_nbit #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  always_comb begin
    {borrow, diff} = {1'b0, a} - {1'b0, b};
  end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV_ZERO_ERR_EN to add the dz_err flag reported alongside done.
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
`ifdef DIV_ZERO_ERR_EN
  ,
  output logic             dz_err
`endif
);

  localparam int CNT_W = clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     r_q, r_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
`ifdef DIV_ZERO_ERR_EN
  logic               dz_q, dz_d;
`endif

  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     t_diff;
  logic               t_borrow;
  logic [WIDTH:0]     r_step;
  logic [WIDTH-1:0]   q_step;
  logic               accept;

  // Shift the next dividend bit into the partial remainder, then try subtracting D.
  assign trial = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  sub_nbit #(.N(WIDTH + 1)) u_sub (
    .a      (trial),
    .b      ({1'b0, d_q}),
    .diff   (t_diff),
    .borrow (t_borrow)
  );

  assign r_step = t_borrow ? trial : t_diff;
  assign q_step = {q_q[WIDTH-2:0], ~t_borrow};

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through this block infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    accept  = 1'b0;
`ifdef DIV_ZERO_ERR_EN
    dz_d    = dz_q;
`endif

    unique case (state_q)
      IDLE: accept = start;
      CALC: begin
        r_d = r_step;
        q_d = q_step;
        if (cnt_q == '0) begin
          state_d = DONE;
          quot_d  = q_step;
          rem_d   = r_step[WIDTH-1:0];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        accept  = start;
      end
      default: state_d = IDLE;
    endcase

    // Start is only honoured in IDLE/DONE, so a pulse during CALC never restarts.
    if (accept) begin
      state_d = CALC;
      cnt_d   = CNT_W'(WIDTH - 1);
      r_d     = '0;
      q_d     = dividend;
      d_d     = divisor;
`ifdef DIV_ZERO_ERR_EN
      dz_d    = (divisor == '0);
`endif
    end
  end

  // NOTE: all state, including results and working registers, is reset so an abort mid-CALC
  // leaves no stale values; non-blocking assignments keep the update order-independent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef DIV_ZERO_ERR_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
`ifdef DIV_ZERO_ERR_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign busy      = (state_q == CALC);
  assign done      = (state_q == DONE);
`ifdef DIV_ZERO_ERR_EN
  assign dz_err    = (state_q == DONE) && dz_q;
`endif

endmodule
